// File: rtl/micro_sysmem.sv
// Memory subsystem for the 8-bit accumulator CPU: 62-byte RAM, program loader
// that holds the CPU in reset, and a memory-mapped output port with handshake.
module micro_sysmem #(
  parameter int unsigned     AW        = 6,
  parameter int unsigned     DW        = 8,
  parameter logic [AW-1:0]   OUT_ADDR  = 6'h3F,
  parameter logic [AW-1:0]   STAT_ADDR = 6'h3E
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_din,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic [DW-1:0] mem_dout,
  output logic          cpu_reset,
  input  logic          ld_start,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_last,
  output logic          ld_busy,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_ovf
);

  localparam int unsigned   DEPTH     = int'(STAT_ADDR);
  localparam logic [AW-1:0] LAST_ADDR = STAT_ADDR - AW'(1);

  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          xfer, load_done, enter_load, cpu_wr, out_wr;

  // Reads are purely combinational, so the read strobe carries no information.
  logic unused_mem_read;
  assign unused_mem_read = mem_read;

  // A restart pulse in LOAD wins over a same-cycle transfer.
  assign xfer       = ld_ready && ld_valid && !ld_start;
  assign load_done  = xfer && (ld_last || ptr == LAST_ADDR);
  assign enter_load = ld_start && (state != S_RELEASE);
  assign cpu_wr     = mem_write && (state == S_RUN);
  assign out_wr     = cpu_wr && (mem_addr == OUT_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HOLD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b1;
    ld_busy   = 1'b0;
    ld_ready  = 1'b0;
    case (state)
      S_HOLD: if (ld_start) state_nxt = S_LOAD;
      S_LOAD: begin
        ld_busy  = 1'b1;
        ld_ready = 1'b1;
        if (load_done) state_nxt = S_RELEASE;
      end
      S_RELEASE: state_nxt = S_RUN;
      S_RUN: begin
        cpu_reset = 1'b0;
        if (ld_start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           ptr <= '0;
    else if (enter_load) ptr <= '0;
    else if (xfer)       ptr <= ptr + AW'(1);
  end

  // RAM has no reset so a partial load survives an asynchronous reset.
  always_ff @(posedge clk) begin
    if (xfer)
      mem[ptr] <= ld_data;
    else if (cpu_wr && mem_addr < STAT_ADDR)
      mem[mem_addr] <= mem_din;
  end

  always_comb begin
    mem_dout = '0;
    if (mem_addr == OUT_ADDR)
      mem_dout = out_data;
    else if (mem_addr == STAT_ADDR)
      mem_dout = {{(DW-1){1'b0}}, out_valid};
    else if (mem_addr < STAT_ADDR)
      mem_dout = mem[mem_addr];
  end

  // A write that coincides with a completing handshake refills the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (enter_load) begin
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (out_wr) begin
      if (!out_valid || out_ready) begin
        out_data  <= mem_din;
        out_valid <= 1'b1;
      end else begin
        out_ovf   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
